// File: rtl/coeff_hold_pkg.sv
// coeff_hold_pkg: shared state encoding and counter width for the coefficient hold bank
package coeff_hold_pkg;

    localparam int COUNT_W = 16;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        LOADING = 1'b1
    } state_t;

endpackage

// File: rtl/coeff_hold_lane.sv
// coeff_hold_lane: one channel holding a shadow value, the active value and a dirty bit
module coeff_hold_lane #(
    parameter int W = 32
) (
    input  logic         system1000,
    input  logic         system1000_rstn,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         load,
    output logic [W-1:0] active,
    output logic         dirty
);

    logic [W-1:0] shadow;
    logic [W-1:0] shadow_next;

    // A same-cycle write is part of the image that a load copies to active
    assign shadow_next = wr_en ? wr_data : shadow;

    // Shadow capture, active load on commit and dirty tracking since the last commit
    always_ff @(posedge system1000) begin
        if (!system1000_rstn) begin
            shadow <= '0;
            active <= '0;
            dirty  <= 1'b0;
        end else begin
            shadow <= shadow_next;
            if (load)
                active <= shadow_next;
            dirty <= load ? 1'b0 : (dirty | wr_en);
        end
    end

endmodule

// File: rtl/coeff_hold_bank.sv
// coeff_hold_bank: double-buffered coefficient bank with atomic commit of all channels
module coeff_hold_bank
    import coeff_hold_pkg::*;
#(
    parameter int NCH         = 9,
    parameter int W           = 32,
    parameter int AUTO_COMMIT = 1
) (
    input  logic                                  system1000,
    input  logic                                  system1000_rstn,
    input  logic                                  wr_valid,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] wr_addr,
    input  logic [W-1:0]                          wr_data,
    input  logic                                  commit,
    output logic [NCH*W-1:0]                      coeff,
    output logic [NCH-1:0]                        dirty,
    output logic                                  busy,
    output logic                                  commit_pulse,
    output logic [15:0]                           commit_count,
    output logic                                  err_addr
);

    state_t               state;
    logic                 wr_ok;
    logic                 trigger;
    logic [NCH-1:0]       wr_en;
    logic [COUNT_W-1:0]   count;

    // Writes beyond the last channel are dropped and only flag an error
    assign wr_ok = wr_valid && (32'(wr_addr) < NCH);

    // A manual commit needs something pending; auto-commit fires once every channel is dirty
    assign trigger = (commit && ((|dirty) || wr_ok)) ||
                     ((AUTO_COMMIT == 1) && (&(dirty | wr_en)));

    assign busy         = (state == LOADING);
    assign commit_count = count;

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        assign wr_en[i] = wr_ok && (32'(wr_addr) == i);
        coeff_hold_lane #(.W(W)) u_lane (
            .system1000      (system1000),
            .system1000_rstn (system1000_rstn),
            .wr_en           (wr_en[i]),
            .wr_data         (wr_data),
            .load            (trigger),
            .active          (coeff[i*W +: W]),
            .dirty           (dirty[i])
        );
    end

    // State follows whether any channel will be pending after this edge
    always_ff @(posedge system1000) begin
        if (!system1000_rstn)
            state <= IDLE;
        else
            state <= trigger ? IDLE : (((|dirty) || wr_ok) ? LOADING : IDLE);
    end

    // Commit strobe aligned with the new coeff, wrapping commit counter, sticky address error
    always_ff @(posedge system1000) begin
        if (!system1000_rstn) begin
            commit_pulse <= 1'b0;
            count        <= '0;
            err_addr     <= 1'b0;
        end else begin
            commit_pulse <= trigger;
            count        <= trigger ? count + 1'b1 : count;
            err_addr     <= err_addr | (wr_valid && !wr_ok);
        end
    end

endmodule

// File: tb/tb_coeff_hold_bank.sv
// tb_coeff_hold_bank: directed stimulus on manual- and auto-commit banks against a behavioural model
module tb_coeff_hold_bank;

    localparam int NCH = 9;
    localparam int W   = 32;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             wr_valid = 1'b0;
    logic             commit = 1'b0;
    logic [3:0]       wr_addr = '0;
    logic [W-1:0]     wr_data = '0;

    logic [NCH*W-1:0] coeff0, coeff1;
    logic [NCH-1:0]   dirty0, dirty1;
    logic             busy0, busy1, pulse0, pulse1, err0, err1;
    logic [15:0]      cnt0, cnt1;

    int tests = 0;
    int fails = 0;

    logic [W-1:0]     m_sh [2][NCH];
    logic [W-1:0]     m_act[2][NCH];
    logic [NCH-1:0]   m_dirty[2];
    logic [15:0]      m_cnt[2];
    logic             m_pulse[2];
    logic             m_err[2];
    logic             m_valid = 1'b0;

    always #5 clk = ~clk;

    coeff_hold_bank #(.NCH(NCH), .W(W), .AUTO_COMMIT(0)) d0 (
        .system1000(clk), .system1000_rstn(rstn), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .coeff(coeff0), .dirty(dirty0), .busy(busy0),
        .commit_pulse(pulse0), .commit_count(cnt0), .err_addr(err0)
    );

    coeff_hold_bank #(.NCH(NCH), .W(W), .AUTO_COMMIT(1)) d1 (
        .system1000(clk), .system1000_rstn(rstn), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .coeff(coeff1), .dirty(dirty1), .busy(busy1),
        .commit_pulse(pulse1), .commit_count(cnt1), .err_addr(err1)
    );

    task automatic chk(input string name, input logic [NCH*W-1:0] got, input logic [NCH*W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [W-1:0] d);
        wr_valid = 1'b1; wr_addr = 4'(a); wr_data = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    // Behavioural model: bank 0 is manual-only, bank 1 also auto-commits when all channels are dirty
    always @(posedge clk) begin
        logic           ok;
        logic           trig;
        logic [NCH-1:0] nd;
        for (int k = 0; k < 2; k++) begin
            if (!rstn) begin
                for (int i = 0; i < NCH; i++) begin
                    m_sh[k][i] = '0;
                    m_act[k][i] = '0;
                end
                m_dirty[k] = '0; m_cnt[k] = '0; m_pulse[k] = 1'b0; m_err[k] = 1'b0;
            end else begin
                ok = wr_valid && (wr_addr < 4'd9);
                nd = m_dirty[k] | (ok ? (9'd1 << wr_addr) : 9'd0);
                if (ok) m_sh[k][wr_addr] = wr_data;
                if (wr_valid && !ok) m_err[k] = 1'b1;
                trig = (commit && nd != '0) || (k == 1 && nd == '1);
                if (trig) begin
                    for (int i = 0; i < NCH; i++) m_act[k][i] = m_sh[k][i];
                    m_dirty[k] = '0;
                    m_cnt[k] = m_cnt[k] + 16'd1;
                end else begin
                    m_dirty[k] = nd;
                end
                m_pulse[k] = trig;
            end
        end
        if (!rstn) m_valid = 1'b1;
    end

    // Every-cycle comparison of both banks against the model, away from the rising edge
    always @(negedge clk) begin
        logic [NCH*W-1:0] e0, e1;
        if (m_valid) begin
            for (int i = 0; i < NCH; i++) begin
                e0[i*W +: W] = m_act[0][i];
                e1[i*W +: W] = m_act[1][i];
            end
            chk("m0_coeff", coeff0, e0);
            chk("m0_dirty", NCH*W'(dirty0), NCH*W'(m_dirty[0]));
            chk("m0_busy", NCH*W'(busy0), NCH*W'(m_dirty[0] != '0));
            chk("m0_pulse", NCH*W'(pulse0), NCH*W'(m_pulse[0]));
            chk("m0_count", NCH*W'(cnt0), NCH*W'(m_cnt[0]));
            chk("m0_err", NCH*W'(err0), NCH*W'(m_err[0]));
            chk("m1_coeff", coeff1, e1);
            chk("m1_dirty", NCH*W'(dirty1), NCH*W'(m_dirty[1]));
            chk("m1_busy", NCH*W'(busy1), NCH*W'(m_dirty[1] != '0));
            chk("m1_pulse", NCH*W'(pulse1), NCH*W'(m_pulse[1]));
            chk("m1_count", NCH*W'(cnt1), NCH*W'(m_cnt[1]));
            chk("m1_err", NCH*W'(err1), NCH*W'(m_err[1]));
        end
    end

    initial begin
        rstn = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        chk("rst_coeff", coeff0, '0);
        chk("rst_busy", NCH*W'(busy0), '0);
        chk("rst_count", NCH*W'(cnt0), '0);
        chk("rst_err", NCH*W'(err0), '0);

        for (int i = 0; i < NCH; i++) wr(i, 32'h100 + i);
        chk("t036_busy", NCH*W'(busy0), NCH*W'(1));
        chk("t036_prepulse", NCH*W'(pulse0), '0);
        do_commit();
        for (int i = 0; i < NCH; i++) chk("t036_ch", NCH*W'(coeff0[i*W +: W]), NCH*W'(32'h100 + i));
        chk("t036_pulse", NCH*W'(pulse0), NCH*W'(1));
        chk("t036_count", NCH*W'(cnt0), NCH*W'(1));
        chk("t036_dirty", NCH*W'(dirty0), '0);
        tick();
        chk("t036_pulse_end", NCH*W'(pulse0), '0);

        wr(3, 32'hAAAA);
        wr(3, 32'hBBBB);
        chk("t037_err", NCH*W'(err0), '0);
        do_commit();
        chk("t037_ch3", NCH*W'(coeff0[3*W +: W]), NCH*W'(32'hBBBB));
        chk("t037_ch0", NCH*W'(coeff0[0 +: W]), NCH*W'(32'h100));
        chk("t037_ch8", NCH*W'(coeff0[8*W +: W]), NCH*W'(32'h108));
        chk("t037_count", NCH*W'(cnt0), NCH*W'(2));
        tick();

        for (int i = 0; i < NCH - 1; i++) wr(i, 32'h200 + i);
        chk("t038_noauto", NCH*W'(pulse1), '0);
        chk("t038_busy", NCH*W'(busy1), NCH*W'(1));
        wr(8, 32'h208);
        chk("t038_pulse", NCH*W'(pulse1), NCH*W'(1));
        for (int i = 0; i < NCH; i++) chk("t038_ch", NCH*W'(coeff1[i*W +: W]), NCH*W'(32'h200 + i));
        chk("t038_manual_hold", NCH*W'(coeff0[0 +: W]), NCH*W'(32'h100));
        do_commit();
        tick();

        wr(9, 32'hDEAD);
        chk("t039_err", NCH*W'(err0), NCH*W'(1));
        chk("t039_dirty", NCH*W'(dirty0), '0);
        tick(); tick();
        chk("t039_err_sticky", NCH*W'(err0), NCH*W'(1));
        do_commit();
        chk("t039_idle_pulse", NCH*W'(pulse0), '0);
        chk("t039_idle_count", NCH*W'(cnt0), NCH*W'(3));

        wr(0, 32'h55);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        do_commit();
        chk("t040_coeff", coeff0, '0);
        chk("t040_busy", NCH*W'(busy0), '0);
        chk("t040_pulse", NCH*W'(pulse0), '0);
        chk("t040_err", NCH*W'(err0), '0);

        wr_valid = 1'b1; commit = 1'b1; wr_addr = 4'd0;
        for (int n = 0; n < 65535; n++) begin
            wr_data = n;
            tick();
        end
        wr_valid = 1'b0; commit = 1'b0;
        chk("t041_ffff", NCH*W'(cnt0), NCH*W'(16'hFFFF));
        wr(1, 32'h77);
        do_commit();
        chk("t041_wrap", NCH*W'(cnt0), '0);
        chk("t041_pulse", NCH*W'(pulse0), NCH*W'(1));
        chk("t041_ch1", NCH*W'(coeff0[1*W +: W]), NCH*W'(32'h77));
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
